// File: rtl/laser_pkg.sv
// Shared types and constants for the player laser shot.
package laser_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned LASER_W = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Spawn row above the plane, clamped at the screen top.
    function automatic logic [COORD_W-1:0] spawn_row(input logic [COORD_W-1:0] plane_y,
                                                     input logic [COORD_W-1:0] laser_h);
        return (plane_y < laser_h) ? '0 : plane_y - laser_h;
    endfunction

endpackage

// File: rtl/laser_launcher_fire_edge_sync.sv
// Two-flop synchroniser for the raw fire button plus a rising-edge detector on the
// synchronised level.
module fire_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/laser_launcher.sv
// Player laser shot: launch on frame_tick, rise per frame, retire on top exit or hit, then cool down.
// Optional LASER_AUTOFIRE_EN: the held fire level (not just its edge) re-arms the launcher.
module laser_launcher
    import laser_pkg::*;
#(
    parameter int unsigned SPEED    = 4,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned PLANE_W  = 32,
    parameter int unsigned LASER_H  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               fire,
    input  logic [COORD_W-1:0] plane_x,
    input  logic [COORD_W-1:0] plane_y,
    input  logic               hit,
    output logic [COORD_W-1:0] laser_ox,
    output logic [COORD_W-1:0] laser_oy,
    output logic               laser_active,
    output logic               shot_fired
);

    localparam logic [COORD_W-1:0] X_OFF   = COORD_W'(PLANE_W / 2) - COORD_W'(LASER_W / 2);
    localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] H_C     = COORD_W'(LASER_H);
    localparam logic [CNT_W-1:0]   COOL_C  = CNT_W'(COOLDOWN);

    logic fire_level;
    logic fire_rise;
    logic set_req;

    fire_edge_sync u_fire_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (fire),
        .level    (fire_level),
        .rise     (fire_rise)
    );

`ifdef LASER_AUTOFIRE_EN
    assign set_req = fire_level;
`else
    assign set_req = fire_rise & fire_level;
`endif

    state_t             state_q, state_d;
    coord_t             pos_q, pos_d;
    logic               active_q, active_d;
    logic               shot_q, shot_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            active_q  <= 1'b0;
            shot_q    <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            active_q  <= active_d;
            shot_q    <= shot_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state; launches wait for frame_tick so the sprite never tears mid-frame.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        active_d  = active_q;
        shot_d    = 1'b0;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if ((pending_q || set_req) && frame_tick) begin
                    state_d   = FLY;
                    pos_d.x   = plane_x + X_OFF;
                    pos_d.y   = spawn_row(plane_y, H_C);
                    active_d  = 1'b1;
                    shot_d    = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    pending_d = pending_q | set_req;
                end
            end
            FLY: begin
                // hit outranks frame_tick; compare before subtracting so oy never wraps
                if (hit || (frame_tick && (pos_q.y < SPEED_C))) begin
                    state_d  = COOL;
                    active_d = 1'b0;
                    cnt_d    = COOL_C;
                end else if (frame_tick) begin
                    pos_d.y = pos_q.y - SPEED_C;
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign laser_ox     = pos_q.x;
    assign laser_oy     = pos_q.y;
    assign laser_active = active_q;
    assign shot_fired   = shot_q;

endmodule

// File: tb/tb_laser_launcher.sv
// Directed and randomised checks of laser_launcher against a shot-level reference model.
module tb_laser_launcher;

    localparam int SPEED    = 4;
    localparam int COOLDOWN = 8;
    localparam int PLANE_W  = 32;
    localparam int LASER_H  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        fire;
    logic        hit;
    logic [10:0] plane_x;
    logic [10:0] plane_y;
    logic [10:0] laser_ox;
    logic [10:0] laser_oy;
    logic        laser_active;
    logic        shot_fired;

    always #5 clk = ~clk;

    laser_launcher #(
        .SPEED    (SPEED),
        .COOLDOWN (COOLDOWN),
        .PLANE_W  (PLANE_W),
        .LASER_H  (LASER_H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .fire         (fire),
        .plane_x      (plane_x),
        .plane_y      (plane_y),
        .hit          (hit),
        .laser_ox     (laser_ox),
        .laser_oy     (laser_oy),
        .laser_active (laser_active),
        .shot_fired   (shot_fired)
    );

    // Reference model: a shot is a launch row plus a count of frames flown.
    bit          f_hist[$];
    bit          m_flying;
    bit          m_cooling;
    bit          m_pending;
    int          m_x;
    int          m_launch_y;
    int          m_ticks;
    int          m_cool_left;
    logic [10:0] e_ox;
    logic [10:0] e_oy;
    logic        e_active;
    logic        e_shot;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void model_outputs();
        e_ox     = 11'(m_x);
        e_oy     = 11'(m_launch_y - SPEED * m_ticks);
        e_active = m_flying;
    endfunction

    function automatic void model_reset();
        f_hist      = {1'b0, 1'b0, 1'b0};
        m_flying    = 1'b0;
        m_cooling   = 1'b0;
        m_pending   = 1'b0;
        m_x         = 0;
        m_launch_y  = 0;
        m_ticks     = 0;
        m_cool_left = 0;
        e_shot      = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_edge(input bit f, input bit ft, input bit h);
        int n;
        bit lvl;
        bit prev;
        bit req;
        n    = f_hist.size();
        lvl  = f_hist[n-2];
        prev = f_hist[n-3];
`ifdef LASER_AUTOFIRE_EN
        req = lvl;
`else
        req = lvl & ~prev;
`endif
        e_shot = 1'b0;
        if (m_flying) begin
            if (h || (ft && (SPEED * (m_ticks + 1) > m_launch_y))) begin
                m_flying    = 1'b0;
                m_cooling   = 1'b1;
                m_cool_left = COOLDOWN;
            end else if (ft) begin
                m_ticks++;
            end
        end else if (m_cooling) begin
            if (m_cool_left == 0) m_cooling = 1'b0;
            else if (ft) m_cool_left--;
        end else begin
            if ((m_pending || req) && ft) begin
                m_flying   = 1'b1;
                m_x        = (int'(plane_x) + PLANE_W / 2 - 4) % 2048;
                m_launch_y = (int'(plane_y) < LASER_H) ? 0 : int'(plane_y) - LASER_H;
                m_ticks    = 0;
                m_pending  = 1'b0;
                e_shot     = 1'b1;
            end else begin
                m_pending = m_pending || req;
            end
        end
        f_hist.push_back(f);
        if (f_hist.size() > 4) void'(f_hist.pop_front());
        model_outputs();
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ox"}, laser_ox, e_ox);
        chk({tag, "_oy"}, laser_oy, e_oy);
        chk({tag, "_active"}, 11'(laser_active), 11'(e_active));
        chk({tag, "_shot"}, 11'(shot_fired), 11'(e_shot));
    endtask

    task automatic step(input bit f, input bit ft, input bit h);
        fire       = f;
        frame_tick = ft;
        hit        = h;
        @(posedge clk);
        model_edge(f, ft, h);
        #1;
        check_all("model");
    endtask

    task automatic frame(input bit f);
        step(f, 1'b1, 1'b0);
        step(f, 1'b0, 1'b0);
        step(f, 1'b0, 1'b0);
    endtask

    initial begin
        int shots;
        rst        = 1'b0;
        fire       = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        plane_x    = 11'd200;
        plane_y    = 11'd400;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // Launch from (200,400) and first climb step
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_shot", 11'(shot_fired), 11'd1);
        chk("t2_ox", laser_ox, 11'd212);
        chk("t2_oy", laser_oy, 11'd392);
        chk("t2_active", 11'(laser_active), 11'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_shot_pulse", 11'(shot_fired), 11'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_oy_climb", laser_oy, 11'd388);

        // Fresh press during FLY, held through COOL: no relaunch without release
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_hit_active", 11'(laser_active), 11'd0);
        shots = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            shots += int'(shot_fired);
            repeat (3) begin
                step(1'b1, 1'b0, 1'b0);
                shots += int'(shot_fired);
            end
        end
`ifndef LASER_AUTOFIRE_EN
        chk("t5_no_relaunch", 11'(shots), 11'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_fresh_press", 11'(shot_fired), 11'd1);
`endif

        // hit together with frame_tick at oy=300
        step(1'b0, 1'b0, 1'b1);
        repeat (10) frame(1'b0);
        plane_y = 11'd308;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_launch_oy", laser_oy, 11'd300);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_active", 11'(laser_active), 11'd0);
        chk("t4_oy_hold", laser_oy, 11'd300);

        // Top exit from oy=6 without wrap, then cooldown back to IDLE
        repeat (10) frame(1'b0);
        plane_y = 11'd14;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_oy6", laser_oy, 11'd6);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_oy2", laser_oy, 11'd2);
        chk("t3_active_oy2", 11'(laser_active), 11'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_exit_active", 11'(laser_active), 11'd0);
        chk("t3_exit_oy", laser_oy, 11'd2);
        repeat (8) frame(1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_idle_after_cool", 11'(shot_fired), 11'd1);

        // Randomised traffic
        begin
            bit f = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (i % 200 == 0) begin
                    plane_x = 11'($urandom_range(0, 700));
                    plane_y = 11'($urandom_range(0, 479));
                end
                if ($urandom_range(0, 19) == 0) f = ~f;
                step(f, $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
            end
        end

        // Async reset while flying at oy=100
        step(1'b0, 1'b0, 1'b1);
        repeat (10) frame(1'b0);
        plane_y = 11'd108;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t1_oy100", laser_oy, 11'd100);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_rst_ox", laser_ox, 11'd0);
        chk("t1_rst_oy", laser_oy, 11'd0);
        chk("t1_rst_active", 11'(laser_active), 11'd0);
        chk("t1_rst_shot", 11'(shot_fired), 11'd0);
        model_reset();
        rst = 1'b1;
        repeat (6) frame(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
